// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register and its helpers.
package pipe_pkg;

    // Stage occupancy, encoded as {skid_v, main_v}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_e;

    localparam int unsigned MAX_CTRL_W = 64;
    localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = '0;

    localparam int unsigned IFID_CTRL_W  = 4;
    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IDEX_CTRL_W  = 16;
    localparam int unsigned IDEX_DATA_W  = 128;
    localparam int unsigned EXMEM_CTRL_W = 8;
    localparam int unsigned EXMEM_DATA_W = 101;
    localparam int unsigned MEMWB_CTRL_W = 4;
    localparam int unsigned MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CntOne = W'(1);
    localparam logic [W-1:0] CntMax = '1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CTRL_W-1:0] NopCtrl = CTRL_W'(NOP_CTRL);

    logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] main_c_q, main_c_d, skid_c_q, skid_c_d;
    logic [DATA_W-1:0] main_d_q, main_d_d, skid_d_q, skid_d_d;
    logic              accept, fire;
    pipe_state_e       state;

    assign state     = pipe_state_e'({skid_v_q, main_v_q});
    assign in_ready  = (SKID != 0) ? ~skid_v_q : (~main_v_q | out_ready);
    assign out_valid = main_v_q;
    assign out_ctrl  = main_v_q ? main_c_q : NopCtrl;
    assign out_data  = main_d_q;
    assign accept    = in_valid & in_ready;
    assign fire      = main_v_q & out_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_c_d = main_c_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_c_d = skid_c_q;
        skid_d_d = skid_d_q;
        if (SKID != 0) begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_v_d = 1'b1;
                        main_c_d = in_ctrl;
                        main_d_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        main_c_d = in_ctrl;
                        main_d_d = in_data;
                    end else if (accept) begin
                        skid_v_d = 1'b1;
                        skid_c_d = in_ctrl;
                        skid_d_d = in_data;
                    end else if (fire) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    // Skid entry is older than anything upstream, so it moves up first
                    if (fire) begin
                        main_c_d = skid_c_q;
                        main_d_d = skid_d_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end else begin
            skid_v_d = 1'b0;
            skid_c_d = '0;
            skid_d_d = '0;
            if (accept) begin
                main_v_d = 1'b1;
                main_c_d = in_ctrl;
                main_d_d = in_data;
            end else if (fire) begin
                main_v_d = 1'b0;
            end
        end
        if (flush) begin
            main_v_d = 1'b0;
            main_c_d = '0;
            main_d_d = '0;
            skid_v_d = 1'b0;
            skid_c_d = '0;
            skid_d_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_v_q <= 1'b0;
            main_c_q <= '0;
            main_d_q <= '0;
            skid_v_q <= 1'b0;
            skid_c_q <= '0;
            skid_d_q <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_c_q <= main_c_d;
            main_d_q <= main_d_d;
            skid_v_q <= skid_v_d;
            skid_c_q <= skid_c_d;
            skid_d_q <= skid_d_d;
        end
    end

    pipe_sat_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(1'b0),
        .inc  (main_v_q & ~out_ready & ~flush),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a vector table drives the skid-buffered stage, hand sequences
// cover counter saturation and the combinational-ready variant.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        ir1, ov1, ir4, ov4, ir0, ov0;
    logic [15:0] oc1, oc4, oc0, sc1, sc0;
    logic [31:0] od1, od4, od0;
    logic [3:0]  sc4;
    logic        iv0, or0;
    logic [15:0] ic0;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
        .out_ctrl(oc4), .out_data(od4), .stall_cnt(sc4)
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv0), .in_ready(ir0),
        .in_ctrl(ic0), .in_data({16'hDA7A, ic0}), .out_valid(ov0), .out_ready(or0),
        .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0)
    );

    typedef struct {
        logic        rn;
        logic        fl;
        logic        iv;
        logic [15:0] ic;
        logic        orr;
        logic        ov;
        logic [15:0] oc;
        logic        ir;
        logic [15:0] sc;
        logic        cd;
        logic [31:0] od;
    } vec_t;

    typedef struct {
        logic        iv;
        logic [15:0] ic;
        logic        orr;
        logic        ir;
        logic        ov;
        logic [15:0] oc;
    } s0_t;

    localparam int NV = 23;
    localparam int NS = 6;
    vec_t vecs [NV];
    s0_t  s0v  [NS];

    function automatic vec_t mk(input logic rn, input logic fl, input logic iv,
                                input logic [15:0] ic, input logic orr, input logic ov,
                                input logic [15:0] oc, input logic ir, input logic [15:0] sc,
                                input logic cd);
        vec_t v;
        v.rn = rn; v.fl = fl; v.iv = iv; v.ic = ic; v.orr = orr;
        v.ov = ov; v.oc = oc; v.ir = ir; v.sc = sc; v.cd = cd;
        v.od = ov ? {16'hDA7A, oc} : 32'h0;
        return v;
    endfunction

    function automatic s0_t mk0(input logic iv, input logic [15:0] ic, input logic orr,
                                input logic ir, input logic ov, input logic [15:0] oc);
        s0_t s;
        s.iv = iv; s.ic = ic; s.orr = orr; s.ir = ir; s.ov = ov; s.oc = oc;
        return s;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        //            rn fl iv ic        or ov oc        ir sc  cd
        vecs[0]  = mk(0, 0, 1, 16'h0055, 1, 0, 16'h0000, 1, 0, 1);
        vecs[1]  = mk(0, 0, 1, 16'h0055, 1, 0, 16'h0000, 1, 0, 1);
        vecs[2]  = mk(1, 0, 1, 16'h0001, 1, 1, 16'h0001, 1, 0, 1);
        vecs[3]  = mk(1, 0, 1, 16'h0002, 1, 1, 16'h0002, 1, 0, 1);
        vecs[4]  = mk(1, 0, 1, 16'h0003, 1, 1, 16'h0003, 1, 0, 1);
        vecs[5]  = mk(1, 0, 1, 16'h0004, 1, 1, 16'h0004, 1, 0, 1);
        vecs[6]  = mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 16'h00A1, 1, 1, 16'h00A1, 1, 0, 1);
        vecs[8]  = mk(1, 0, 1, 16'h00B2, 0, 1, 16'h00A1, 0, 1, 1);
        vecs[9]  = mk(1, 0, 1, 16'h00C3, 0, 1, 16'h00A1, 0, 2, 1);
        vecs[10] = mk(1, 0, 1, 16'h00C3, 0, 1, 16'h00A1, 0, 3, 1);
        vecs[11] = mk(1, 0, 1, 16'h00C3, 1, 1, 16'h00B2, 1, 3, 1);
        vecs[12] = mk(1, 0, 1, 16'h00C3, 1, 1, 16'h00C3, 1, 3, 1);
        vecs[13] = mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 3, 0);
        vecs[14] = mk(1, 0, 1, 16'h0011, 0, 1, 16'h0011, 1, 3, 1);
        vecs[15] = mk(1, 0, 1, 16'h0022, 0, 1, 16'h0011, 0, 4, 1);
        vecs[16] = mk(1, 1, 1, 16'h0033, 0, 0, 16'h0000, 1, 4, 1);
        vecs[17] = mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 4, 1);
        vecs[18] = mk(1, 1, 1, 16'h0044, 1, 0, 16'h0000, 1, 4, 1);
        vecs[19] = mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 4, 1);
        vecs[20] = mk(1, 0, 1, 16'h0055, 0, 1, 16'h0055, 1, 4, 1);
        vecs[21] = mk(0, 1, 1, 16'h0066, 0, 0, 16'h0000, 1, 0, 1);
        vecs[22] = mk(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 1);

        //             iv ic        or ir ov oc
        s0v[0] = mk0(1, 16'h0101, 1, 1, 1, 16'h0101);
        s0v[1] = mk0(1, 16'h0102, 0, 0, 1, 16'h0101);
        s0v[2] = mk0(1, 16'h0102, 1, 1, 1, 16'h0102);
        s0v[3] = mk0(1, 16'h0103, 1, 1, 1, 16'h0103);
        s0v[4] = mk0(0, 16'h0000, 0, 0, 1, 16'h0103);
        s0v[5] = mk0(0, 16'h0000, 1, 1, 0, 16'h0000);

        iv0 = 1'b0; ic0 = '0; or0 = 1'b1;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b1;

        for (int i = 0; i < NV; i++) begin
            reset     = vecs[i].rn;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_ctrl   = vecs[i].ic;
            in_data   = {16'hDA7A, vecs[i].ic};
            out_ready = vecs[i].orr;
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(ov1), 32'(vecs[i].ov));
            check("out_ctrl", i, 32'(oc1), 32'(vecs[i].oc));
            check("in_ready", i, 32'(ir1), 32'(vecs[i].ir));
            check("stall_cnt", i, 32'(sc1), 32'(vecs[i].sc));
            if (vecs[i].cd) check("out_data", i, od1, vecs[i].od);
        end

        // Saturation: one beat parked at the output with no downstream ready
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0077; in_data = {16'hDA7A, 16'h0077};
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sat_cnt4_10", 0, 32'(sc4), 32'd10);
        check("sat_cnt16_10", 0, 32'(sc1), 32'd10);
        repeat (10) @(posedge clk);
        #1;
        check("sat_cnt4_20", 0, 32'(sc4), 32'd15);
        check("sat_cnt16_20", 0, 32'(sc1), 32'd20);
        @(posedge clk);
        #1;
        check("sat_cnt4_21", 0, 32'(sc4), 32'd15);
        check("sat_cnt16_21", 0, 32'(sc1), 32'd21);
        check("sat_out_valid", 0, 32'(ov4), 32'd1);
        check("sat_out_ctrl", 0, 32'(oc4), 32'h0077);
        check("sat_out_data", 0, od4, {16'hDA7A, 16'h0077});
        check("sat_in_ready", 0, 32'(ir4), 32'd1);

        // Combinational-ready variant with out_ready toggling while streaming
        for (int i = 0; i < NS; i++) begin
            iv0 = s0v[i].iv;
            ic0 = s0v[i].ic;
            or0 = s0v[i].orr;
            #1;
            check("s0_in_ready", i, 32'(ir0), 32'(s0v[i].ir));
            @(posedge clk);
            #1;
            check("s0_out_valid", i, 32'(ov0), 32'(s0v[i].ov));
            check("s0_out_ctrl", i, 32'(oc0), 32'(s0v[i].oc));
            if (s0v[i].ov) check("s0_out_data", i, od0, {16'hDA7A, s0v[i].oc});
        end
        check("s0_stall_cnt", 0, 32'(sc0), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
